// File: rtl/rlbp_seq_pkg.sv
// ----------------------------------------------------------------------------
// rlbp_seq_pkg
// Shared definitions for the RLBP window sequencer: the FSM state encoding,
// the 3x3 nibble window geometry and a helper that maps a nibble index to the
// core row register (1..3) it belongs to.
// ----------------------------------------------------------------------------
package rlbp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_FIRE = 3'd3,
        ST_WAIT = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int NIBBLES_PER_WIN = 9;
    localparam int NIBBLES_PER_ROW = 3;
    localparam int NIB_IDX_W       = 4;

    // Index 0-2 -> row 1, 3-5 -> row 2, 6-8 -> row 3.
    function automatic logic [1:0] row_of(input logic [NIB_IDX_W-1:0] idx);
        if (idx < NIB_IDX_W'(NIBBLES_PER_ROW))
            return 2'd1;
        else if (idx < NIB_IDX_W'(2 * NIBBLES_PER_ROW))
            return 2'd2;
        else
            return 2'd3;
    endfunction

endpackage

// File: rtl/rlbp_seq_watchdog.sv
// ----------------------------------------------------------------------------
// rlbp_seq_watchdog
// WAIT-state watchdog for rlbp_seq_ctrl. Compiled only when the macro
// RLBP_SEQ_TIMEOUT_EN is defined.
// Down-counter reloaded with TIMEOUT_CYC-1 on clr; it decrements on every
// enabled cycle and expire flags the enabled cycle in which it reaches zero,
// i.e. the TIMEOUT_CYC-th enabled cycle after a clear.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   clr    - reload the counter
//   en     - count this cycle (FSM in WAIT)
//   expire - terminal count reached during an enabled cycle
// ----------------------------------------------------------------------------
`ifdef RLBP_SEQ_TIMEOUT_EN
module rlbp_seq_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= LOAD_VAL;
        else if (clr)
            cnt_q <= LOAD_VAL;
        else if (en && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign expire = en && (cnt_q == '0);

endmodule
`endif

// File: rtl/rlbp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rlbp_seq_ctrl
// Frame sequencer for the RLBP core: for each of num_win windows it clears
// the core, streams 9 pixel nibbles into the three row registers, fires the
// core and waits for its result.
// Optional feature: define RLBP_SEQ_TIMEOUT_EN to add a WAIT watchdog
// (rlbp_seq_watchdog) that ends the frame with err_timeout_o after
// TIMEOUT_CYC cycles without core_done_i. Without it WAIT never times out.
//
// state | meaning
// IDLE  | no frame; start_i accepted here only
// CLR   | reset_fsm_o pulse, nibble index cleared
// LOAD  | accept 9 nibbles, steer them to row 1/2/3
// FIRE  | core_start_o pulse, watchdog reload
// WAIT  | wait for core_done_i (or watchdog expiry)
// NEXT  | win_done_o pulse, window count + 1
// DONE  | frame_done_o pulse
//
// Ports:
//   wb_clk_i, wb_rst_i        - clock / async active-high reset
//   start_i, abort_i          - frame start pulse / abort level
//   num_win_i                 - windows per frame, latched on start
//   pix_valid_i, pix_data_i   - nibble stream in; pix_ready_o = accept
//   d_o, ce_d1_o..ce_d3_o     - nibble and row load enables to the core
//   reset_fsm_o, core_start_o - core clear / start pulses
//   core_done_i               - core result ready
//   win_done_o, frame_done_o  - completion pulses
//   busy_o, win_cnt_o         - not IDLE / windows completed
//   err_timeout_o             - sticky watchdog flag
// ----------------------------------------------------------------------------
module rlbp_seq_ctrl
    import rlbp_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int WIN_W       = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] num_win_i,
    input  logic             pix_valid_i,
    input  logic [3:0]       pix_data_i,
    output logic             pix_ready_o,
    output logic [3:0]       d_o,
    output logic             ce_d1_o,
    output logic             ce_d2_o,
    output logic             ce_d3_o,
    output logic             reset_fsm_o,
    output logic             core_start_o,
    input  logic             core_done_i,
    output logic             win_done_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic [WIN_W-1:0] win_cnt_o,
    output logic             err_timeout_o
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("rlbp_seq_ctrl: TIMEOUT_CYC must be at least 1");
    end

    state_t               state_q, state_d;
    logic [NIB_IDX_W-1:0] nib_idx_q;
    logic [WIN_W-1:0]     num_win_q;
    logic [WIN_W-1:0]     win_cnt_q;
    logic [WIN_W-1:0]     win_cnt_inc;
    logic                 start_acc;
    logic                 nib_acc;
    logic                 nib_last;
    logic                 wd_expire;
    logic [1:0]           row;

    // abort_i beats start_i, so an aborted start must not touch the latches.
    assign start_acc   = (state_q == ST_IDLE) && start_i && !abort_i;
    assign nib_acc     = (state_q == ST_LOAD) && pix_valid_i;
    assign nib_last    = (nib_idx_q == NIB_IDX_W'(NIBBLES_PER_WIN - 1));
    assign win_cnt_inc = win_cnt_q + 1'b1;
    assign row         = row_of(nib_idx_q);

`ifdef RLBP_SEQ_TIMEOUT_EN
    logic err_timeout_q;

    rlbp_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (state_q == ST_FIRE),
        .en     (state_q == ST_WAIT),
        .expire (wd_expire)
    );

    // core_done_i in the expiry cycle wins: the window completes normally.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            err_timeout_q <= 1'b0;
        else if (start_acc)
            err_timeout_q <= 1'b0;
        else if ((state_q == ST_WAIT) && wd_expire && !core_done_i && !abort_i)
            err_timeout_q <= 1'b1;
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign wd_expire     = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = (num_win_i == '0) ? ST_DONE : ST_CLR;
                ST_CLR:  state_d = ST_LOAD;
                ST_LOAD: if (pix_valid_i && nib_last) state_d = ST_FIRE;
                ST_FIRE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (core_done_i)
                        state_d = ST_NEXT;
                    else if (wd_expire)
                        state_d = ST_DONE;
                end
                ST_NEXT: state_d = (win_cnt_inc == num_win_q) ? ST_DONE : ST_CLR;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register only (plus the LOAD
    // pass-through of the nibble stream), so every pulse is one clean cycle.
    always_comb begin
        pix_ready_o  = 1'b0;
        d_o          = 4'h0;
        ce_d1_o      = 1'b0;
        ce_d2_o      = 1'b0;
        ce_d3_o      = 1'b0;
        reset_fsm_o  = 1'b0;
        core_start_o = 1'b0;
        win_done_o   = 1'b0;
        frame_done_o = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        case (state_q)
            ST_CLR:  reset_fsm_o = 1'b1;
            ST_LOAD: begin
                pix_ready_o = 1'b1;
                d_o         = pix_data_i;
                ce_d1_o     = pix_valid_i && (row == 2'd1);
                ce_d2_o     = pix_valid_i && (row == 2'd2);
                ce_d3_o     = pix_valid_i && (row == 2'd3);
            end
            ST_FIRE: core_start_o = 1'b1;
            ST_NEXT: win_done_o   = 1'b1;
            ST_DONE: frame_done_o = 1'b1;
            default: ;
        endcase
    end

    // The equality check in NEXT ends the frame before win_cnt can wrap.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            nib_idx_q <= '0;
            num_win_q <= '0;
            win_cnt_q <= '0;
        end else begin
            if (start_acc) begin
                num_win_q <= num_win_i;
                win_cnt_q <= '0;
            end else if ((state_q == ST_NEXT) && !abort_i) begin
                win_cnt_q <= win_cnt_inc;
            end

            if (state_q == ST_CLR)
                nib_idx_q <= '0;
            else if (nib_acc)
                nib_idx_q <= nib_idx_q + 1'b1;
        end
    end

    assign win_cnt_o = win_cnt_q;

endmodule

// File: tb/tb_rlbp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rlbp_seq_ctrl
// Scoreboard bench for rlbp_seq_ctrl. Expected output events (core clear,
// nibble loads with row steering, core start, window/frame completion) are
// queued as stimulus is driven; a negedge monitor pops and compares each event
// the DUT produces. Timeout scenarios run only with RLBP_SEQ_TIMEOUT_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rlbp_seq_ctrl;

    localparam int WIN_W  = 8;
    localparam int TO_CYC = 16;

    localparam logic [3:0] EV_CLR = 4'd1;
    localparam logic [3:0] EV_CE  = 4'd2;
    localparam logic [3:0] EV_CST = 4'd3;
    localparam logic [3:0] EV_WIN = 4'd4;
    localparam logic [3:0] EV_FRM = 4'd5;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] val;
    } ev_t;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             start_i;
    logic             abort_i;
    logic [WIN_W-1:0] num_win_i;
    logic             pix_valid_i;
    logic [3:0]       pix_data_i;
    logic             pix_ready_o;
    logic [3:0]       d_o;
    logic             ce_d1_o, ce_d2_o, ce_d3_o;
    logic             reset_fsm_o;
    logic             core_start_o;
    logic             core_done_i;
    logic             win_done_o;
    logic             frame_done_o;
    logic             busy_o;
    logic [WIN_W-1:0] win_cnt_o;
    logic             err_timeout_o;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    ev_t exp_q[$];
    ev_t obs_ev;
    ev_t exp_ev;
    bit  obs_have;
    logic [21:0] all_out;

    rlbp_seq_ctrl #(
        .TIMEOUT_CYC (TO_CYC),
        .WIN_W       (WIN_W)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .num_win_i     (num_win_i),
        .pix_valid_i   (pix_valid_i),
        .pix_data_i    (pix_data_i),
        .pix_ready_o   (pix_ready_o),
        .d_o           (d_o),
        .ce_d1_o       (ce_d1_o),
        .ce_d2_o       (ce_d2_o),
        .ce_d3_o       (ce_d3_o),
        .reset_fsm_o   (reset_fsm_o),
        .core_start_o  (core_start_o),
        .core_done_i   (core_done_i),
        .win_done_o    (win_done_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o),
        .win_cnt_o     (win_cnt_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    assign all_out = {pix_ready_o, d_o, ce_d1_o, ce_d2_o, ce_d3_o, reset_fsm_o,
                      core_start_o, win_done_o, frame_done_o, busy_o, win_cnt_o,
                      err_timeout_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic void push(input logic [3:0] k, input logic [7:0] v);
        exp_q.push_back({k, v});
    endfunction

    // Row model: nibbles 1-3 row 1, 4-6 row 2, 7-9 row 3 (one-hot, bit0=row 1).
    function automatic logic [2:0] row_onehot(input int i);
        if (i < 3) return 3'b001;
        if (i < 6) return 3'b010;
        return 3'b100;
    endfunction

    task automatic push_loads(input int count);
        for (int i = 0; i < count; i++)
            push(EV_CE, {1'b0, row_onehot(i), 4'(i + 1)});
    endtask

    task automatic push_window();
        push(EV_CLR, 8'h00);
        push_loads(9);
        push(EV_CST, 8'h00);
    endtask

    // Leaves the DUT in FIRE (core_start cycle) after the 9th accept.
    task automatic stream(input bit gaps);
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                pix_valid_i = 1'b0;
                pix_data_i  = 4'hF;
                core_done_i = 1'b1;
                tick();
                core_done_i = 1'b0;
            end
            pix_valid_i = 1'b1;
            pix_data_i  = 4'(i + 1);
            tick();
        end
        pix_valid_i = 1'b0;
        pix_data_i  = 4'h0;
        chk("cstart_lat", core_start_o, 1);
    endtask

    task automatic run_frame(input int n, input bit gaps);
        push_window();
        num_win_i = 8'(n);
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        num_win_i = 8'(n + 5);
        chk("start_busy", busy_o, 1);
        chk("cnt_clear", win_cnt_o, 0);
        for (int w = 0; w < n; w++) begin
            tick();
            chk("load_ready", pix_ready_o, 1);
            stream(gaps);
            tick();
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            tick();
            chk("wait_busy", busy_o, 1);
            push(EV_WIN, 8'(w));
            if (w == n - 1)
                push(EV_FRM, {1'b0, 7'(n)});
            else
                push_window();
            core_done_i = 1'b1;
            tick();
            core_done_i = 1'b0;
            tick();
        end
        tick();
        chk("idle_busy", busy_o, 0);
        chk("cnt_hold", win_cnt_o, n);
    endtask

    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            chk("ce_gated", {ce_d1_o, ce_d2_o, ce_d3_o} & {3{~pix_valid_i}}, 0);
            chk("pulse_onehot",
                32'($countones({reset_fsm_o, ce_d1_o, ce_d2_o, ce_d3_o,
                                core_start_o, win_done_o, frame_done_o}) > 1), 0);
            obs_have = 1'b1;
            if (reset_fsm_o)
                obs_ev = {EV_CLR, 8'h00};
            else if (ce_d1_o || ce_d2_o || ce_d3_o)
                obs_ev = {EV_CE, 1'b0, ce_d3_o, ce_d2_o, ce_d1_o, d_o};
            else if (core_start_o)
                obs_ev = {EV_CST, 8'h00};
            else if (win_done_o)
                obs_ev = {EV_WIN, win_cnt_o};
            else if (frame_done_o)
                obs_ev = {EV_FRM, err_timeout_o, win_cnt_o[6:0]};
            else
                obs_have = 1'b0;
            if (obs_have) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(obs_ev), 0);
                end else begin
                    exp_ev = exp_q.pop_front();
                    chk("event", 32'(obs_ev), 32'(exp_ev));
                end
            end
        end
    end

    initial begin
        wb_rst_i    = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        pix_valid_i = 1'b0;
        pix_data_i  = 4'h0;
        core_done_i = 1'b0;
        num_win_i   = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_outputs", 32'(all_out), 0);
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;
        tick();

        // Two windows, gap-free stream, then a 3-window frame with valid toggling.
        run_frame(2, 1'b0);
        run_frame(3, 1'b1);

        // Zero windows: straight to DONE, count cleared by the accepted start.
        push(EV_FRM, 8'h00);
        num_win_i = '0;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        chk("zero_done", frame_done_o, 1);
        tick();
        chk("zero_idle", busy_o, 0);

        // Abort in WAIT, then core_done in IDLE, then start+abort together.
        push_window();
        num_win_i = 8'd2;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        tick();
        stream(1'b0);
        tick();
        chk("abort_pre_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_idle", busy_o, 0);
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        tick();
        chk("abort_quiet", busy_o, 0);
        num_win_i = 8'd1;
        start_i   = 1'b1;
        abort_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        abort_i   = 1'b0;
        chk("start_abort_idle", busy_o, 0);
        tick();
        chk("start_abort_stay", busy_o, 0);
        chk("abort_q_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of LOAD, then a clean frame.
        push(EV_CLR, 8'h00);
        push_loads(4);
        num_win_i = 8'd1;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            pix_valid_i = 1'b1;
            pix_data_i  = 4'(i + 1);
            tick();
        end
        pix_valid_i = 1'b1;
        pix_data_i  = 4'h5;
        #1;
        chk("pre_rst_ce2", ce_d2_o, 1);
        wb_rst_i = 1'b1;
        #1;
        chk("rst_async", 32'(all_out), 0);
        pix_valid_i = 1'b0;
        pix_data_i  = 4'h0;
        tick();
        tick();
        wb_rst_i = 1'b0;
        tick();
        chk("rst_q_empty", exp_q.size(), 0);
        run_frame(1, 1'b0);

`ifdef RLBP_SEQ_TIMEOUT_EN
        // No core_done: 16 WAIT cycles, then DONE with the error flag.
        push_window();
        push(EV_FRM, 8'h80);
        num_win_i = 8'd1;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        tick();
        stream(1'b0);
        repeat (TO_CYC) tick();
        chk("to_not_yet", frame_done_o, 0);
        chk("to_err_not_yet", err_timeout_o, 0);
        tick();
        chk("to_frame", frame_done_o, 1);
        chk("to_err", err_timeout_o, 1);
        tick();
        chk("to_idle", busy_o, 0);
        chk("to_err_sticky", err_timeout_o, 1);

        // core_done in the expiry cycle completes the window normally.
        push_window();
        push(EV_WIN, 8'h00);
        push(EV_FRM, 8'h01);
        num_win_i = 8'd1;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        chk("to_err_clear", err_timeout_o, 0);
        tick();
        stream(1'b0);
        repeat (TO_CYC) tick();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        chk("to_race_win", win_done_o, 1);
        tick();
        tick();
        chk("to_race_err", err_timeout_o, 0);
        chk("to_race_idle", busy_o, 0);
`endif

        tick();
        chk("final_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
